// File: rtl/chacha_keystream_xor_if.sv
// Block-function request/response bus between the keystream XOR stage (master)
// and the ChaCha block function (slave).
interface chacha_keystream_xor_if #(
    parameter int KEY_WIDTH         = 256,
    parameter int NONCE_WIDTH       = 96,
    parameter int BLOCK_COUNT_WIDTH = 32,
    parameter int BLOCK_WIDTH       = 512
);
    logic [KEY_WIDTH-1:0]         bf_key;
    logic [NONCE_WIDTH-1:0]       bf_nonce;
    logic [BLOCK_COUNT_WIDTH-1:0] bf_block_count;
    logic                         bf_start;
    logic                         bf_ready;
    logic                         bf_valid;
    logic [BLOCK_WIDTH-1:0]       bf_out;

    modport master (
        output bf_key, bf_nonce, bf_block_count, bf_start,
        input  bf_ready, bf_valid, bf_out
    );

    modport slave (
        input  bf_key, bf_nonce, bf_block_count, bf_start,
        output bf_ready, bf_valid, bf_out
    );
endinterface

// File: rtl/chacha_keystream_xor.sv
// ChaCha keystream XOR stage: requests 512-bit keystream blocks and XORs them
// word by word onto the data stream through a one-deep output register.
module chacha_keystream_xor #(
    parameter int KEY_WIDTH         = 256,
    parameter int NONCE_WIDTH       = 96,
    parameter int BLOCK_COUNT_WIDTH = 32,
    parameter int WIDTH             = 32,
    parameter int BLOCK_WIDTH       = 512
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         msg_start,
    input  logic [KEY_WIDTH-1:0]         key,
    input  logic [NONCE_WIDTH-1:0]       nonce,
    input  logic [BLOCK_COUNT_WIDTH-1:0] init_count,
    output logic                         busy,
    input  logic [WIDTH-1:0]             din,
    input  logic                         din_valid,
    input  logic                         din_last,
    output logic                         din_ready,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    output logic                         dout_last,
    input  logic                         dout_ready,
    chacha_keystream_xor_if.master       bf,
    output logic                         ctr_wrap
);
    localparam int WORDS = BLOCK_WIDTH / WIDTH;
    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, STREAM, DRAIN} state_t;

    state_t                         state_reg;
    logic [KEY_WIDTH-1:0]           key_reg;
    logic [NONCE_WIDTH-1:0]         nonce_reg;
    logic [BLOCK_COUNT_WIDTH-1:0]   count_reg;
    logic [BLOCK_COUNT_WIDTH-1:0]   count_next;
    logic                           bf_start_reg;
    logic [BLOCK_WIDTH-1:0]         ks_reg;
    logic [IDX_W-1:0]               idx_reg;
    logic [IDX_W-1:0]               idx_next;
    logic [WIDTH-1:0]               dout_reg;
    logic                           dout_valid_reg;
    logic                           dout_last_reg;
    logic                           busy_reg;
    logic                           ctr_wrap_reg;

    logic [WIDTH-1:0]               ks_words [WORDS];
    logic [WIDTH-1:0]               ks_word;
    logic                           din_ready_c;
    logic                           accept;
    logic                           last_idx;
    logic                           count_wraps;

    // Word gi of the captured block sits in the gi-th least significant WIDTH bits.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_ks_words
            assign ks_words[gi] = ks_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign ks_word     = ks_words[idx_reg];
    // Output register frees up in the same cycle it is drained downstream.
    assign din_ready_c = (state_reg == STREAM) && (!dout_valid_reg || dout_ready);
    assign accept      = din_valid && din_ready_c;
    assign last_idx    = (idx_reg == IDX_W'(WORDS - 1));
    assign idx_next    = idx_reg + IDX_W'(1);
    assign count_next  = count_reg + BLOCK_COUNT_WIDTH'(1);
    assign count_wraps = (count_reg == {BLOCK_COUNT_WIDTH{1'b1}});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            key_reg        <= '0;
            nonce_reg      <= '0;
            count_reg      <= '0;
            bf_start_reg   <= 1'b0;
            ks_reg         <= '0;
            idx_reg        <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            dout_last_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            ctr_wrap_reg   <= 1'b0;
        end else begin
            bf_start_reg <= 1'b0;

            if (accept) begin
                dout_reg       <= din ^ ks_word;
                dout_last_reg  <= din_last;
                dout_valid_reg <= 1'b1;
            end else if (dout_ready) begin
                dout_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (msg_start) begin
                        key_reg      <= key;
                        nonce_reg    <= nonce;
                        count_reg    <= init_count;
                        ctr_wrap_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= REQ;
                    end
                end
                REQ: begin
                    if (bf.bf_ready) begin
                        bf_start_reg <= 1'b1;
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bf.bf_valid) begin
                        ks_reg    <= bf.bf_out;
                        idx_reg   <= '0;
                        state_reg <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        idx_reg <= idx_next;
                        // A final word always ends the message, even at the block boundary.
                        if (din_last) begin
                            state_reg <= DRAIN;
                        end else if (last_idx) begin
                            count_reg <= count_next;
                            if (count_wraps) begin
                                ctr_wrap_reg <= 1'b1;
                            end
                            state_reg <= REQ;
                        end
                    end
                end
                DRAIN: begin
                    if (dout_valid_reg && dout_ready) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bf.bf_key         = key_reg;
    assign bf.bf_nonce       = nonce_reg;
    assign bf.bf_block_count = count_reg;
    assign bf.bf_start       = bf_start_reg;
    assign busy              = busy_reg;
    assign din_ready         = din_ready_c;
    assign dout              = dout_reg;
    assign dout_valid        = dout_valid_reg;
    assign dout_last         = dout_last_reg;
    assign ctr_wrap          = ctr_wrap_reg;
endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Bench for chacha_keystream_xor: block-function stub plus a word-level
// reference model of the expected ciphertext and block requests.
module tb_chacha_keystream_xor;
    logic         clk = 1'b0;
    logic         resetn;
    logic         msg_start;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  init_count;
    logic         busy;
    logic [31:0]  din;
    logic         din_valid;
    logic         din_last;
    logic         din_ready;
    logic [31:0]  dout;
    logic         dout_valid;
    logic         dout_last;
    logic         dout_ready;
    logic         ctr_wrap;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chacha_keystream_xor_if bf_if ();

    chacha_keystream_xor dut (
        .clk        (clk),
        .resetn     (resetn),
        .msg_start  (msg_start),
        .key        (key),
        .nonce      (nonce),
        .init_count (init_count),
        .busy       (busy),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .dout_ready (dout_ready),
        .bf         (bf_if),
        .ctr_wrap   (ctr_wrap)
    );

    // Block-function stub: word i = {count[15:0], i}, valid for one cycle 3 cycles after start.
    logic [255:0] cur_key;
    logic [95:0]  cur_nonce;
    int           stub_cd = 0;
    logic [31:0]  stub_cnt;
    logic [511:0] stub_blk;
    logic [31:0]  start_log [$];
    bit           keyok_log [$];

    assign bf_if.bf_ready = (stub_cd == 0);

    always @(posedge clk) begin
        bf_if.bf_valid <= 1'b0;
        if (stub_cd > 0) begin
            stub_cd <= stub_cd - 1;
            if (stub_cd == 1) begin
                for (int i = 0; i < 16; i++) stub_blk[32*i +: 32] = {stub_cnt[15:0], 16'(i)};
                bf_if.bf_valid <= 1'b1;
                bf_if.bf_out   <= stub_blk;
            end
        end
        if (bf_if.bf_start === 1'b1) begin
            stub_cd  <= 3;
            stub_cnt <= bf_if.bf_block_count;
            start_log.push_back(bf_if.bf_block_count);
            keyok_log.push_back(bf_if.bf_key === cur_key && bf_if.bf_nonce === cur_nonce);
        end
    end

    // Reference model: word j uses block init+j/16, keystream word j%16.
    function automatic logic [31:0] ks_model(input logic [31:0] init, input int j);
        logic [31:0] blk;
        blk = init + 32'(j / 16);
        return {blk[15:0], 16'(j % 16)};
    endfunction

    logic [31:0] din_q [$];
    logic [31:0] out_q [$];
    bit          last_q [$];
    int          stable_err, refill_err, sim_err, busy_delay;
    bit          timed_out;

    task automatic run_msg(input logic [31:0] init, input int bp, input int gaps);
        int sent = 0;
        int n = din_q.size();
        int last_cyc = -1;
        bit prev_hold = 0;
        bit refill = 0;
        logic [31:0] prev_dout = '0;
        logic prev_last = 1'b0;
        out_q.delete(); last_q.delete(); start_log.delete(); keyok_log.delete();
        stable_err = 0; refill_err = 0; sim_err = 0; busy_delay = -1; timed_out = 0;
        for (int i = 0; i < 8; i++) cur_key[32*i +: 32] = $urandom;
        for (int i = 0; i < 3; i++) cur_nonce[32*i +: 32] = $urandom;
        @(negedge clk);
        msg_start = 1'b1; key = cur_key; nonce = cur_nonce; init_count = init;
        din_valid = 1'b1; din = din_q[0]; din_last = (n == 1); dout_ready = 1'b1;
        #1;
        if (din_ready !== 1'b0) sim_err++;
        @(negedge clk);
        msg_start = 1'b0; key = ~cur_key; nonce = ~cur_nonce; init_count = $urandom;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            dout_ready = (bp == 0) ? 1'b1 : (bp == 1) ? 1'((cyc % 2) == 1) : 1'($urandom_range(0, 1));
            if (sent < n && (gaps == 0 || $urandom_range(0, 3) != 0)) begin
                din_valid = 1'b1; din = din_q[sent]; din_last = (sent == n - 1);
            end else begin
                din_valid = 1'b0; din = $urandom; din_last = 1'b0;
            end
            #1;
            if (prev_hold && (dout_valid !== 1'b1 || dout !== prev_dout || dout_last !== prev_last))
                stable_err++;
            if (refill) begin
                if (din_ready !== 1'b0) refill_err++;
                if (bf_if.bf_valid === 1'b1) refill = 0;
            end
            if (last_cyc >= 0 && busy_delay < 0 && busy === 1'b0) busy_delay = cyc - last_cyc;
            if (dout_valid === 1'b1 && dout_ready) begin
                out_q.push_back(dout);
                last_q.push_back(dout_last === 1'b1);
                if (dout_last === 1'b1) last_cyc = cyc;
            end
            prev_hold = (dout_valid === 1'b1) && !dout_ready;
            prev_dout = dout;
            prev_last = dout_last;
            if (din_valid && din_ready === 1'b1) begin
                sent++;
                if (sent % 16 == 0 && sent < n) refill = 1;
            end
            if (busy_delay >= 0) break;
            @(negedge clk);
        end
        if (busy_delay < 0) timed_out = 1;
        din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; msg_start = 1'b0; key = '0; nonce = '0; init_count = '0;
        din = '0; din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dout, dout_valid, dout_last, busy, din_ready, bf_if.bf_start, ctr_wrap,
             bf_if.bf_block_count, bf_if.bf_key, bf_if.bf_nonce} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: dout=%h valid=%b last=%b busy=%b ready=%b start=%b wrap=%b cnt=%h, required all zero",
                     dout, dout_valid, dout_last, busy, din_ready, bf_if.bf_start, ctr_wrap, bf_if.bf_block_count);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_block();
        int nlast = 0;
        din_q.delete();
        repeat (16) din_q.push_back(32'h0);
        run_msg(32'd5, 0, 0);
        checks++;
        if (timed_out || out_q.size() != 16) begin
            failures++; $display("FAIL single_count: got %0d words timeout=%0d, required 16", out_q.size(), timed_out);
        end
        checks++;
        if (start_log.size() != 1 || start_log[0] !== 32'd5 || !keyok_log[0]) begin
            failures++; $display("FAIL single_start: got %0d starts, required one with count 5 and latched key", start_log.size());
        end
        for (int i = 0; i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== {16'h0005, 16'(i)}) begin
                failures++; $display("FAIL single_word%0d: got %h, required %h", i, out_q[i], {16'h0005, 16'(i)});
            end
            if (last_q[i]) nlast++;
        end
        checks++;
        if (nlast != 1 || out_q.size() != 16 || !last_q[15]) begin
            failures++; $display("FAIL single_last: got %0d last flags, required one on word 15", nlast);
        end
        checks++;
        if (busy_delay != 1) begin
            failures++; $display("FAIL single_busy_drop: got %0d cycles, required 1", busy_delay);
        end
        checks++;
        if (sim_err != 0) begin
            failures++; $display("FAIL start_din_ready: din_ready high with msg_start in idle, required 0");
        end
        $display("single_block: %0d words, %0d starts", out_q.size(), start_log.size());
    endtask

    task automatic test_multi_block();
        din_q.delete();
        repeat (20) din_q.push_back(32'hFFFFFFFF);
        run_msg(32'd1, 0, 0);
        checks++;
        if (start_log.size() != 2 || start_log[0] !== 32'd1 || start_log[1] !== 32'd2) begin
            failures++; $display("FAIL multi_starts: got %0d starts, required counts 1 then 2", start_log.size());
        end
        checks++;
        if (out_q.size() != 20 || out_q[16] !== ~32'h00020000) begin
            failures++; $display("FAIL multi_word17: got %0d words, word16=%h, required 20 and %h",
                                 out_q.size(), (out_q.size() > 16) ? out_q[16] : 32'hx, ~32'h00020000);
        end
        checks++;
        if (refill_err != 0) begin
            failures++; $display("FAIL multi_refill_ready: din_ready high %0d cycles during refill, required 0", refill_err);
        end
        for (int i = 0; i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== (32'hFFFFFFFF ^ ks_model(32'd1, i))) begin
                failures++; $display("FAIL multi_word%0d: got %h, required %h", i, out_q[i], 32'hFFFFFFFF ^ ks_model(32'd1, i));
            end
        end
        $display("multi_block: %0d words, %0d starts", out_q.size(), start_log.size());
    endtask

    task automatic test_short_then_new();
        logic [31:0] d0;
        din_q.delete();
        repeat (3) din_q.push_back($urandom);
        run_msg(32'd40, 0, 0);
        checks++;
        if (start_log.size() != 1 || out_q.size() != 3) begin
            failures++; $display("FAIL short_single_req: got %0d starts %0d words, required 1 and 3", start_log.size(), out_q.size());
        end
        din_q.delete();
        repeat (3) din_q.push_back($urandom);
        d0 = din_q[0];
        run_msg(32'd9, 0, 0);
        checks++;
        if (start_log.size() != 1 || start_log[0] !== 32'd9 || out_q.size() != 3 || out_q[0] !== (d0 ^ {16'd9, 16'd0})) begin
            failures++; $display("FAIL short_fresh_block: got %0d words word0=%h, required block 9 word0=%h",
                                 out_q.size(), (out_q.size() > 0) ? out_q[0] : 32'hx, d0 ^ {16'd9, 16'd0});
        end
        $display("short_then_new: %0d words, %0d starts", out_q.size(), start_log.size());
    endtask

    task automatic test_backpressure();
        din_q.delete();
        repeat (40) din_q.push_back($urandom);
        run_msg(32'd300, 1, 0);
        checks++;
        if (stable_err != 0) begin
            failures++; $display("FAIL bp_stable: dout changed %0d times while stalled, required 0", stable_err);
        end
        checks++;
        if (timed_out || out_q.size() != 40) begin
            failures++; $display("FAIL bp_count: got %0d words, required 40", out_q.size());
        end
        for (int i = 0; i < out_q.size() && i < 40; i++) begin
            checks++;
            if (out_q[i] !== (din_q[i] ^ ks_model(32'd300, i))) begin
                failures++; $display("FAIL bp_word%0d: got %h, required %h", i, out_q[i], din_q[i] ^ ks_model(32'd300, i));
            end
        end
        $display("backpressure: %0d words, %0d stalls broken", out_q.size(), stable_err);
    endtask

    task automatic test_wrap();
        din_q.delete();
        repeat (17) din_q.push_back($urandom);
        run_msg(32'hFFFFFFFF, 0, 0);
        checks++;
        if (start_log.size() != 2 || start_log[0] !== 32'hFFFFFFFF || start_log[1] !== 32'd0) begin
            failures++; $display("FAIL wrap_starts: got %0d starts, required FFFFFFFF then 0", start_log.size());
        end
        checks++;
        if (ctr_wrap !== 1'b1) begin
            failures++; $display("FAIL wrap_flag: got %b, required 1", ctr_wrap);
        end
        checks++;
        if (out_q.size() != 17 || out_q[16] !== (din_q[16] ^ 32'h00000000)) begin
            failures++; $display("FAIL wrap_word16: got %0d words, required 17 with block 0 keystream", out_q.size());
        end
        din_q.delete();
        repeat (2) din_q.push_back($urandom);
        run_msg(32'd3, 0, 0);
        checks++;
        if (ctr_wrap !== 1'b0) begin
            failures++; $display("FAIL wrap_clear: got %b, required 0", ctr_wrap);
        end
        $display("wrap: flag now %b", ctr_wrap);
    endtask

    task automatic test_reset_midwait();
        int bad = 0;
        start_log.delete(); keyok_log.delete();
        for (int i = 0; i < 8; i++) cur_key[32*i +: 32] = $urandom;
        @(negedge clk);
        msg_start = 1'b1; key = cur_key; init_count = 32'd7;
        @(negedge clk);
        msg_start = 1'b0;
        for (int c = 0; c < 50 && start_log.size() == 0; c++) @(negedge clk);
        checks++;
        if (start_log.size() != 1) begin
            failures++; $display("FAIL rst_wait_start: got %0d starts, required 1", start_log.size());
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({dout, dout_valid, dout_last, busy, din_ready, bf_if.bf_start, ctr_wrap,
             bf_if.bf_block_count, bf_if.bf_key, bf_if.bf_nonce} !== '0) begin
            failures++; $display("FAIL rst_wait_outputs: busy=%b start=%b cnt=%h, required all zero",
                                 busy, bf_if.bf_start, bf_if.bf_block_count);
        end
        @(negedge clk);
        resetn = 1'b1; dout_ready = 1'b1; din_valid = 1'b1; din = $urandom;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dout_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b0) bad++;
        end
        din_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL rst_late_valid: %0d cycles with activity after reset, required 0", bad);
        end
        $display("reset_midwait: %0d active cycles", bad);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int n;
            int nb;
            logic [31:0] init;
            bit exp_wrap;
            n = $urandom_range(1, 40);
            init = (t % 2 == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 2)) : $urandom;
            nb = (n + 15) / 16;
            exp_wrap = ({1'b0, init} + 33'(nb - 1)) > 33'h0FFFFFFFF;
            din_q.delete();
            for (int i = 0; i < n; i++) din_q.push_back($urandom);
            run_msg(init, 2, 1);
            checks++;
            if (timed_out || out_q.size() != n || stable_err != 0 || refill_err != 0) begin
                failures++; $display("FAIL rand%0d_flow: got %0d words stall_err=%0d refill_err=%0d, required %0d 0 0",
                                     t, out_q.size(), stable_err, refill_err, n);
            end
            checks++;
            if (start_log.size() != nb) begin
                failures++; $display("FAIL rand%0d_nreq: got %0d requests, required %0d", t, start_log.size(), nb);
            end
            for (int k = 0; k < start_log.size() && k < nb; k++) begin
                checks++;
                if (start_log[k] !== init + 32'(k) || !keyok_log[k]) begin
                    failures++; $display("FAIL rand%0d_req%0d: got count %h, required %h with latched key", t, k, start_log[k], init + 32'(k));
                end
            end
            for (int i = 0; i < out_q.size() && i < n; i++) begin
                checks++;
                if (out_q[i] !== (din_q[i] ^ ks_model(init, i)) || last_q[i] != (i == n - 1)) begin
                    failures++; $display("FAIL rand%0d_word%0d: got %h last=%0d, required %h last=%0d",
                                         t, i, out_q[i], last_q[i], din_q[i] ^ ks_model(init, i), i == n - 1);
                end
            end
            checks++;
            if (ctr_wrap !== exp_wrap) begin
                failures++; $display("FAIL rand%0d_wrap: got %b, required %b", t, ctr_wrap, exp_wrap);
            end
            $display("random %0d: n=%0d init=%h words=%0d starts=%0d", t, n, init, out_q.size(), start_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_multi_block();
        test_short_then_new();
        test_backpressure();
        test_wrap();
        test_reset_midwait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
